// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection address generator: geometry
// defaults, the address type and the per-channel handshake states.
package edge_pkg;

    localparam int IMG_W_DEF      = 146;
    localparam int WIN_DEF        = 5;
    localparam int OUT_W_DEF      = IMG_W_DEF - WIN_DEF + 1;
    localparam int WR_PER_WIN_DEF = 9;

    typedef logic [31:0] addr_t;

    typedef enum logic {
        READY,
        UPDATE
    } chan_state_t;

endpackage

// File: rtl/window_raster_counter.sv
// Nested wrap counters for a WIN x WIN window sliding in raster order:
// tap column/row inside the window, then window origin column/row.
module window_raster_counter
    import edge_pkg::*;
#(
    parameter int WIN   = WIN_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        advance,
    output logic [15:0] kx,
    output logic [15:0] ky,
    output logic [15:0] wx,
    output logic [15:0] wy,
    output logic        window_done
);

    localparam logic [15:0] TAP_LAST = 16'(WIN - 1);
    localparam logic [15:0] WIN_LAST = 16'(OUT_W - 1);

    // Flags the advance that consumes the final tap of the current window.
    always_comb begin
        window_done = advance && (kx == TAP_LAST) && (ky == TAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            kx <= '0;
            ky <= '0;
            wx <= '0;
            wy <= '0;
        end else if (advance) begin
            if (kx != TAP_LAST) begin
                kx <= kx + 16'd1;
            end else begin
                kx <= '0;
                if (ky != TAP_LAST) begin
                    ky <= ky + 16'd1;
                end else begin
                    ky <= '0;
                    if (wx != WIN_LAST) begin
                        wx <= wx + 16'd1;
                    end else begin
                        wx <= '0;
                        wy <= (wy == WIN_LAST) ? 16'd0 : wy + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/edge_address_counter.sv
// Read/write SRAM address generator for the edge-detection datapath; two
// independent handshake channels, each advancing one address per pulse.
module edge_address_counter
    import edge_pkg::*;
#(
    parameter int    IMG_W      = IMG_W_DEF,
    parameter int    WIN        = WIN_DEF,
    parameter int    WR_PER_WIN = WR_PER_WIN_DEF,
    parameter addr_t RBASE      = 32'h0000_0000,
    parameter addr_t WBASE      = 32'h0010_0000,
    parameter int    BPP        = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_inc_raddr,
    input  logic        i_inc_waddr,
    output logic [31:0] o_raddr,
    output logic [31:0] o_waddr,
    output logic        o_r_ready,
    output logic        o_w_ready
);

    localparam int          OUT_W    = IMG_W - WIN + 1;
    localparam logic [31:0] W_LAST   = 32'(OUT_W * OUT_W * WR_PER_WIN - 1);
    localparam logic [15:0] WIN_LAST = 16'(OUT_W - 1);
    localparam addr_t       PIX_STEP = addr_t'(BPP);
    // Leaving the last window of a row jumps over the WIN-1 columns no window starts on.
    localparam addr_t       ROW_STEP = addr_t'(BPP * WIN);

    chan_state_t r_state;
    chan_state_t w_state;
    logic        r_accept;
    logic [15:0] kx;
    logic [15:0] ky;
    logic [15:0] wx;
    logic [15:0] wy;
    logic        window_done;
    addr_t       win_origin;
    addr_t       tap_offset;
    logic [31:0] wr_count;

    assign r_accept = (r_state == READY) && i_inc_raddr;

    window_raster_counter #(
        .WIN   (WIN),
        .OUT_W (OUT_W)
    ) u_raster (
        .clk         (clk),
        .n_rst       (n_rst),
        .advance     (r_accept),
        .kx          (kx),
        .ky          (ky),
        .wx          (wx),
        .wy          (wy),
        .window_done (window_done)
    );

    // Byte address of the window origin, tracked incrementally so the only
    // multiply left is the small tap-row offset inside the window.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            win_origin <= RBASE;
        end else if (window_done) begin
            if (wx == WIN_LAST) begin
                win_origin <= (wy == WIN_LAST) ? RBASE : win_origin + ROW_STEP;
            end else begin
                win_origin <= win_origin + PIX_STEP;
            end
        end
    end

    always_comb begin
        tap_offset = PIX_STEP * (addr_t'(ky) * addr_t'(IMG_W) + addr_t'(kx));
    end

    // Read channel: counters step on the accepting edge, address lands one edge later.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state   <= READY;
            o_r_ready <= 1'b1;
            o_raddr   <= RBASE;
        end else if (r_state == READY) begin
            if (i_inc_raddr) begin
                r_state   <= UPDATE;
                o_r_ready <= 1'b0;
            end
        end else begin
            r_state   <= READY;
            o_r_ready <= 1'b1;
            o_raddr   <= win_origin + tap_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            w_state   <= READY;
            o_w_ready <= 1'b1;
            o_waddr   <= WBASE;
            wr_count  <= '0;
        end else if (w_state == READY) begin
            if (i_inc_waddr) begin
                w_state   <= UPDATE;
                o_w_ready <= 1'b0;
                wr_count  <= (wr_count == W_LAST) ? 32'd0 : wr_count + 32'd1;
            end
        end else begin
            w_state   <= READY;
            o_w_ready <= 1'b1;
            o_waddr   <= WBASE + PIX_STEP * wr_count;
        end
    end

endmodule

// File: tb/tb_edge_address_counter.sv
// Randomized bench for edge_address_counter: a default-size instance and a
// small-frame instance run in lockstep against an index-based reference model.
module tb_edge_address_counter;

    localparam int          B_IMG   = 146;
    localparam int          B_WIN   = 5;
    localparam int          B_OUT   = 142;
    localparam int          B_WR    = 9;
    localparam logic [31:0] B_RBASE = 32'h0000_0000;
    localparam logic [31:0] B_WBASE = 32'h0010_0000;
    localparam int          B_BPP   = 1;

    localparam int          S_IMG   = 8;
    localparam int          S_WIN   = 3;
    localparam int          S_OUT   = 6;
    localparam int          S_WR    = 2;
    localparam logic [31:0] S_RBASE = 32'hFFFF_FFF0;
    localparam logic [31:0] S_WBASE = 32'hFFFF_FFC0;
    localparam int          S_BPP   = 2;

    localparam int RT_B = B_OUT * B_OUT * B_WIN * B_WIN;
    localparam int WT_B = B_OUT * B_OUT * B_WR;
    localparam int RT_S = S_OUT * S_OUT * S_WIN * S_WIN;
    localparam int WT_S = S_OUT * S_OUT * S_WR;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        inc_r;
    logic        inc_w;
    logic [31:0] raddr_b, waddr_b, raddr_s, waddr_s;
    logic        rready_b, wready_b, rready_s, wready_s;

    int vec_count  = 0;
    int miscompares = 0;

    int r_cnt_b, w_cnt_b, r_cnt_s, w_cnt_s;
    bit r_busy, w_busy;

    always #5 tb_clk = ~tb_clk;

    edge_address_counter dut_big (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .i_inc_raddr (inc_r),
        .i_inc_waddr (inc_w),
        .o_raddr     (raddr_b),
        .o_waddr     (waddr_b),
        .o_r_ready   (rready_b),
        .o_w_ready   (wready_b)
    );

    edge_address_counter #(
        .IMG_W      (S_IMG),
        .WIN        (S_WIN),
        .WR_PER_WIN (S_WR),
        .RBASE      (S_RBASE),
        .WBASE      (S_WBASE),
        .BPP        (S_BPP)
    ) dut_small (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .i_inc_raddr (inc_r),
        .i_inc_waddr (inc_w),
        .o_raddr     (raddr_s),
        .o_waddr     (waddr_s),
        .o_r_ready   (rready_s),
        .o_w_ready   (wready_s)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address of the idx-th read in raster order, straight from the window formula.
    function automatic logic [31:0] read_addr(input int img_w, input int win, input int out_w,
                                              input logic [31:0] rbase, input int bpp, input int idx);
        int window, k, wx, wy;
        window = idx / (win * win);
        k      = idx % (win * win);
        wx     = window % out_w;
        wy     = window / out_w;
        return rbase + bpp * ((wy + k / win) * img_w + wx + k % win);
    endfunction

    task automatic model_edge(input logic rst, input logic pr, input logic pw);
        if (rst) begin
            r_cnt_b = 0; w_cnt_b = 0; r_cnt_s = 0; w_cnt_s = 0;
            r_busy  = 0; w_busy  = 0;
        end else begin
            if (r_busy) begin
                r_busy  = 0;
                r_cnt_b = (r_cnt_b + 1) % RT_B;
                r_cnt_s = (r_cnt_s + 1) % RT_S;
            end else if (pr) begin
                r_busy = 1;
            end
            if (w_busy) begin
                w_busy  = 0;
                w_cnt_b = (w_cnt_b + 1) % WT_B;
                w_cnt_s = (w_cnt_s + 1) % WT_S;
            end else if (pw) begin
                w_busy = 1;
            end
        end
    endtask

    task automatic check_all();
        check_output("big_raddr", raddr_b, read_addr(B_IMG, B_WIN, B_OUT, B_RBASE, B_BPP, r_cnt_b));
        check_output("big_waddr", waddr_b, B_WBASE + B_BPP * w_cnt_b);
        check_output("big_r_ready", 32'(rready_b), 32'(!r_busy));
        check_output("big_w_ready", 32'(wready_b), 32'(!w_busy));
        check_output("small_raddr", raddr_s, read_addr(S_IMG, S_WIN, S_OUT, S_RBASE, S_BPP, r_cnt_s));
        check_output("small_waddr", waddr_s, S_WBASE + S_BPP * w_cnt_s);
        check_output("small_r_ready", 32'(rready_s), 32'(!r_busy));
        check_output("small_w_ready", 32'(wready_s), 32'(!w_busy));
    endtask

    // Drive one cycle of inputs from the falling edge, then check after the next rise.
    task automatic apply_stimulus(input logic rst, input logic pr, input logic pw);
        n_rst = rst;
        inc_r = pr;
        inc_w = pw;
        @(posedge tb_clk);
        model_edge(rst, pr, pw);
        @(negedge tb_clk);
        check_all();
    endtask

    initial begin
        n_rst = 1'b1;
        inc_r = 1'b0;
        inc_w = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0);
        @(negedge tb_clk);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("reset_raddr", raddr_b, 32'h0000_0000);
        check_output("reset_waddr", waddr_b, 32'h0010_0000);
        check_output("reset_ready", {30'd0, rready_b, wready_b}, 32'd3);

        for (int i = 0; i < 25; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        check_output("second_window_origin", raddr_b, 32'd1);

        // Second pulse of each pair lands while ready is low and must be ignored.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            apply_stimulus(1'b0, 1'b0, 1'b1);
        end
        check_output("write_after_nine", waddr_b, 32'h0010_0009);

        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_output("concurrent_ready_low", {30'd0, rready_b, wready_b}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("concurrent_ready_back", {30'd0, rready_b, wready_b}, 32'd3);
        check_output("concurrent_raddr", raddr_b, 32'd2);
        check_output("concurrent_waddr", waddr_b, 32'h0010_000A);

        for (int i = 0; i < 12000; i++) begin
            apply_stimulus(1'b0, logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 99) < 60));
        end

        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("midupdate_reset_raddr", raddr_s, S_RBASE);
        check_output("midupdate_reset_waddr", waddr_s, S_WBASE);

        for (int i = 0; i < 600; i++) begin
            apply_stimulus(logic'($urandom_range(0, 49) == 0),
                           logic'($urandom_range(0, 99) < 70), logic'($urandom_range(0, 99) < 60));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_address_counter.md
# edge_address_counter

Address generator for the edge-detection datapath. It produces the 32-bit SRAM read address for every pixel of a 5x5 window that slides in raster order over the input image. It also produces a linear write address for the results of each window. The read and write channels advance independently on single-cycle increment pulses, and each channel reports completion through a ready flag.

## Interface
Parameters:
- IMG_W, default 146: input image width and height in pixels (square image).
- WIN, default 5: window edge length. The window count per axis is OUT_W = IMG_W-WIN+1 = 142.
- WR_PER_WIN, default 9: write addresses issued per window.
- RBASE, default 32'h0000_0000: byte address of input pixel (0,0).
- WBASE, default 32'h0010_0000: byte address of the first output word.
- BPP, default 1: bytes per address step.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  reset; synchronous, active-high (asserted at 1, sampled on the clk rising edge), despite the name.
- i_inc_raddr  in  1  one-cycle pulse that requests the next read address.
- i_inc_waddr  in  1  one-cycle pulse that requests the next write address.
- o_raddr  out  32  current read address.
- o_waddr  out  32  current write address.
- o_r_ready  out  1  read address valid; ready for the next increment.
- o_w_ready  out  1  write address valid; ready for the next increment.

## Operation
- Read state:
  - Window origin (wx, wy), each in the range 0..OUT_W-1.
  - Tap index k, in the range 0..WIN*WIN-1.
  - Read address: o_raddr = RBASE + BPP*((wy + k/WIN)*IMG_W + wx + k%WIN).
- Read advance on an accepted i_inc_raddr:
  - If k < 24, k increments.
  - Otherwise k returns to 0 and the window advances one pixel: wx+1, wrapping to 0 with wy+1.
  - After window (141,141) the whole read state returns to (0,0,0). This is a frame wrap with no stall.
- Write state: linear count n, in the range 0..OUT_W*OUT_W*WR_PER_WIN-1 (181476).
  - Write address: o_waddr = WBASE + BPP*n.
  - An accepted i_inc_waddr increments n. After the last value n wraps to 0.
- An increment is accepted only while the matching ready flag is 1. A pulse while ready is 0 is ignored.
- The read and write channels are fully independent. Simultaneous pulses on both are both accepted.
- Reset:
  - Addresses: o_raddr = RBASE, o_waddr = WBASE.
  - Counters: all = 0.
  - Flags: o_r_ready = o_w_ready = 1.
- Address arithmetic is unsigned and 32-bit. Intermediate products use at least 18-bit indices. Overflow of RBASE/WBASE + offset wraps modulo 2^32.

## Timing
- Each channel has a two-state FSM: READY, then UPDATE on an accepted pulse, then READY.
- Increment sampled at edge N:
  - After edge N: ready = 0, and the address still shows the old value.
  - After edge N+1: the new address is registered and ready = 1.
- Increment-to-ready latency is 1 cycle. The earliest next accepted pulse is at edge N+2, giving a maximum rate of one address per 2 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-UPDATE wins: the block returns to the reset values on that edge.

## Structure
- Shared package edge_pkg holds:
  - The IMG_W/WIN/OUT_W/WR_PER_WIN defaults.
  - The addr_t (logic [31:0]) typedef.
  - The chan_state_t enum {READY, UPDATE}.
- One sub-module is natural: window_raster_counter. It holds the (k, wx, wy) nested wrap counters with a single advance input and a window_done output.
- Each of the two channel FSMs is instantiated in the top level.

## Test plan
- Reset: hold n_rst=1 for 2 cycles → o_raddr=RBASE, o_waddr=WBASE, both ready=1.
- First window: 25 read pulses, each waiting for ready → addresses 0,1,2,3,4,146,…,588 (BPP=1, RBASE=0). The 26th address is 1, the origin of window (1,0).
- Row wrap: advance 142 windows → the next window origin address is 146.
- Write channel: 9 pulses → o_waddr WBASE..WBASE+8, then WBASE+9. A pulse while o_w_ready=0 is ignored, with no double step.
- Concurrency: pulse both channels on the same edge → both ready drop for exactly 1 cycle and both addresses advance.
- Full frame: 20164 windows × (25 reads + 9 writes) → both channels end back at RBASE/WBASE. Also assert reset mid-UPDATE → immediate return to the reset values.
